// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: default widths, occupancy width and the common
// stage payload layout used by pipeline stages and their benches.
package pipe_stage_reg_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;
    localparam int OCC_W  = 2;

    typedef struct packed {
        logic [DW_DEF-1:0] data;
        logic [AW_DEF-1:0] ws;
        logic              we;
    } stage_payload_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: payload, write-enable and valid bit with load and clear.
// Clear drops valid and we but keeps the payload bits where they are.
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] pl_i,
    input  logic         we_i,
    output logic         valid_o,
    output logic [W-1:0] pl_o,
    output logic         we_o
);

    logic         valid_q;
    logic [W-1:0] pl_q;
    logic         we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pl_q    <= '0;
            we_q    <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pl_q    <= pl_i;
            we_q    <= we_i;
        end
    end

    assign valid_o = valid_q;
    assign pl_o    = pl_q;
    assign we_o    = we_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register with registered in_ready, flush,
// zero-register write kill and a forwarding query on the main entry.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DW               = DW_DEF,
    parameter int AW               = AW_DEF,
    parameter int ZERO_REG_WE_KILL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic [AW-1:0]    in_ws,
    input  logic             in_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [AW-1:0]    out_ws,
    output logic             out_we,
    input  logic [AW-1:0]    fwd_ws,
    output logic             fwd_hit,
    output logic [DW-1:0]    fwd_data,
    output logic [OCC_W-1:0] occupancy
);

    localparam int PW      = DW + AW;
    localparam bit KILL_EN = (ZERO_REG_WE_KILL != 0);

    // Handshake: a beat moves on a port only in a cycle where valid and ready
    // are both high; valid and payload never depend on the same-cycle ready.
    logic             in_ready_q;
    logic [OCC_W-1:0] occ_q;

    logic          main_valid, skid_valid, main_we, skid_we;
    logic [PW-1:0] main_pl, skid_pl, in_pl, main_pl_d;
    logic          main_we_d, in_we_eff;
    logic          in_fire, out_fire;
    logic          main_load, main_clear, skid_load, skid_clear;
    logic          main_v_d, skid_v_d;

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = main_valid & out_ready;
    assign in_pl     = {in_data, in_ws};
    assign in_we_eff = in_we & ~(KILL_EN & (in_ws == '0));

    // Skid always drains into main first so beats leave in acceptance order.
    assign main_pl_d = skid_valid ? skid_pl : in_pl;
    assign main_we_d = skid_valid ? skid_we : in_we_eff;

    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_v_d   = main_valid;
        skid_v_d   = skid_valid;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
            main_v_d   = 1'b0;
            skid_v_d   = 1'b0;
        end else begin
            if (!main_valid || out_fire) begin
                if (skid_valid || in_fire) begin
                    main_load = 1'b1;
                    main_v_d  = 1'b1;
                end else if (out_fire) begin
                    main_clear = 1'b1;
                    main_v_d   = 1'b0;
                end
            end
            if (skid_valid && out_fire) begin
                skid_clear = 1'b1;
                skid_v_d   = 1'b0;
            end else if (in_fire && main_valid && !out_fire) begin
                skid_load = 1'b1;
                skid_v_d  = 1'b1;
            end
        end
    end

    pipe_entry_reg #(.W(PW)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .pl_i    (main_pl_d),
        .we_i    (main_we_d),
        .valid_o (main_valid),
        .pl_o    (main_pl),
        .we_o    (main_we)
    );

    pipe_entry_reg #(.W(PW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pl_i    (in_pl),
        .we_i    (in_we_eff),
        .valid_o (skid_valid),
        .pl_o    (skid_pl),
        .we_o    (skid_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b1;
            occ_q      <= '0;
        end else begin
            in_ready_q <= ~skid_v_d;
            occ_q      <= OCC_W'(main_v_d) + OCC_W'(skid_v_d);
        end
    end

    assign in_ready  = in_ready_q;
    assign occupancy = occ_q;
    assign out_valid = main_valid;
    assign out_data  = main_pl[PW-1:AW];
    assign out_ws    = main_pl[AW-1:0];
    assign out_we    = main_we & main_valid;
    assign fwd_hit   = main_valid & main_we & (out_ws == fwd_ws) & (fwd_ws != '0);
    assign fwd_data  = out_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, a throughput sequence and
// randomized traffic checked against a queue-based reference model.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_we, out_ready;
    logic        in_ready, out_valid, out_we, fwd_hit;
    logic [31:0] in_data, out_data, fwd_data;
    logic [4:0]  in_ws, out_ws, fwd_ws;
    logic [1:0]  occupancy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ws     (in_ws),
        .in_we     (in_we),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ws    (out_ws),
        .out_we    (out_we),
        .fwd_ws    (fwd_ws),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .occupancy (occupancy)
    );

    typedef struct {
        logic        rst, flush, iv;
        logic [31:0] din;
        logic [4:0]  ws;
        logic        we, ordy;
        logic [4:0]  fws;
        logic        ov;
        logic [31:0] od;
        logic [4:0]  ows;
        logic        owe, ir;
        logic [1:0]  occ;
        logic        fh, chk_pl;
    } vec_t;

    vec_t vecs[20];
    stage_payload_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic r, f, iv, input logic [31:0] din,
                                input logic [4:0] ws, input logic we, ordy,
                                input logic [4:0] fws, input logic ov,
                                input logic [31:0] od, input logic [4:0] ows,
                                input logic owe, ir, input logic [1:0] occ,
                                input logic fh, cp);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.din = din; v.ws = ws; v.we = we;
        v.ordy = ordy; v.fws = fws; v.ov = ov; v.od = od; v.ows = ows;
        v.owe = owe; v.ir = ir; v.occ = occ; v.fh = fh; v.chk_pl = cp;
        return v;
    endfunction

    task automatic drive(input logic r, f, iv, input logic [31:0] d,
                         input logic [4:0] ws, input logic we, ordy,
                         input logic [4:0] fws);
        rst = r; flush = f; in_valid = iv; in_data = d; in_ws = ws;
        in_we = we; out_ready = ordy; fwd_ws = fws;
    endtask

    // Reference model: a FIFO of at most two beats, updated from pre-edge inputs.
    task automatic model_step();
        bit in_f, out_f;
        stage_payload_t p;
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            in_f  = in_valid && (exp_q.size() < 2);
            out_f = out_ready && (exp_q.size() > 0);
            if (out_f) void'(exp_q.pop_front());
            if (in_f) begin
                p.data = in_data;
                p.ws   = in_ws;
                p.we   = in_we && (in_ws != 5'd0);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic model_check();
        int  n;
        bit  hit;
        n = exp_q.size();
        chk("rnd_out_valid", 64'(out_valid), 64'(n != 0));
        chk("rnd_occupancy", 64'(occupancy), 64'(n));
        chk("rnd_in_ready", 64'(in_ready), 64'(n < 2));
        chk("rnd_out_we", 64'(out_we), 64'(n != 0 && exp_q[0].we));
        hit = (n != 0) && exp_q[0].we && (exp_q[0].ws == fwd_ws) && (fwd_ws != 5'd0);
        chk("rnd_fwd_hit", 64'(fwd_hit), 64'(hit));
        if (n != 0) begin
            chk("rnd_out_data", 64'(out_data), 64'(exp_q[0].data));
            chk("rnd_out_ws", 64'(out_ws), 64'(exp_q[0].ws));
        end
        if (hit) chk("rnd_fwd_data", 64'(fwd_data), 64'(exp_q[0].data));
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // reset, streaming, backpressure, flush, zero register / forwarding, mid-stream reset
        vecs[0]  = mk(1,0,0,32'h0,0,0,0,0,           0,32'h0,0,0,1,0,0,1);
        vecs[1]  = mk(1,0,0,32'h0,0,0,0,0,           0,32'h0,0,0,1,0,0,1);
        vecs[2]  = mk(0,0,1,32'hA5A5A5A5,3,1,1,3,    1,32'hA5A5A5A5,3,1,1,1,1,1);
        vecs[3]  = mk(0,0,1,32'h1,4,1,1,3,           1,32'h1,4,1,1,1,0,1);
        vecs[4]  = mk(0,0,0,32'h0,0,0,1,3,           0,32'h0,0,0,1,0,0,0);
        vecs[5]  = mk(0,0,1,32'h10,1,1,0,0,          1,32'h10,1,1,1,1,0,1);
        vecs[6]  = mk(0,0,1,32'h20,2,1,0,0,          1,32'h10,1,1,0,2,0,1);
        vecs[7]  = mk(0,0,1,32'h33,3,1,0,0,          1,32'h10,1,1,0,2,0,1);
        vecs[8]  = mk(0,0,1,32'h33,3,1,1,0,          1,32'h20,2,1,1,1,0,1);
        vecs[9]  = mk(0,0,1,32'h33,3,1,1,0,          1,32'h33,3,1,1,1,0,1);
        vecs[10] = mk(0,0,0,32'h0,0,0,1,0,           0,32'h0,0,0,1,0,0,0);
        vecs[11] = mk(0,0,1,32'h40,1,1,0,0,          1,32'h40,1,1,1,1,0,1);
        vecs[12] = mk(0,0,1,32'h50,2,1,0,0,          1,32'h40,1,1,0,2,0,1);
        vecs[13] = mk(0,1,1,32'h30,5,1,0,0,          0,32'h40,1,0,1,0,0,1);
        vecs[14] = mk(0,0,0,32'h0,0,0,1,0,           0,32'h40,1,0,1,0,0,1);
        vecs[15] = mk(0,0,1,32'h77,0,1,0,0,          1,32'h77,0,0,1,1,0,1);
        vecs[16] = mk(0,0,1,32'h55,7,1,1,7,          1,32'h55,7,1,1,1,1,1);
        vecs[17] = mk(0,0,0,32'h0,0,0,0,0,           1,32'h55,7,1,1,1,0,1);
        vecs[18] = mk(1,0,1,32'h99,1,1,0,0,          0,32'h0,0,0,1,0,0,1);
        vecs[19] = mk(0,0,0,32'h0,0,0,1,0,           0,32'h0,0,0,1,0,0,1);

        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].din, vecs[i].ws,
                  vecs[i].we, vecs[i].ordy, vecs[i].fws);
            @(posedge clk); #1;
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
            chk($sformatf("v%0d_out_we", i), 64'(out_we), 64'(vecs[i].owe));
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].ir));
            chk($sformatf("v%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].occ));
            chk($sformatf("v%0d_fwd_hit", i), 64'(fwd_hit), 64'(vecs[i].fh));
            if (vecs[i].ov || vecs[i].chk_pl) begin
                chk($sformatf("v%0d_out_data", i), 64'(out_data), 64'(vecs[i].od));
                chk($sformatf("v%0d_out_ws", i), 64'(out_ws), 64'(vecs[i].ows));
            end
            if (vecs[i].fh) chk($sformatf("v%0d_fwd_data", i), 64'(fwd_data), 64'(vecs[i].od));
        end

        // Back-to-back stream: each beat must show up the cycle after it is sent.
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 1, 32'h100 + 32'(k), 5'(k + 1), 1, 1, 0);
            @(posedge clk); #1;
            chk($sformatf("tput%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("tput%0d_data", k), 64'(out_data), 64'(32'h100 + 32'(k)));
            chk($sformatf("tput%0d_in_ready", k), 64'(in_ready), 64'd1);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(posedge clk); #1;
        chk("tput_drained", 64'(out_valid), 64'd0);

        exp_q.delete();
        for (int c = 0; c < 1500; c++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)));
            model_step();
            @(posedge clk); #1;
            model_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL accept parameter DW, default 32: data payload width in bits.
REQ-002 SHALL accept parameter AW, default 5: write-select (destination register index) width in bits.
REQ-003 SHALL accept parameter ZERO_REG_WE_KILL, default 1: when 1, a write-enable paired with write-select 0 is dropped on capture.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port flush, input, 1: discard all held entries.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream handshake.
REQ-008 SHALL have ports in_data (input, DW), in_ws (input, AW) and in_we (input, 1): upstream payload.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream handshake.
REQ-010 SHALL have ports out_data (output, DW), out_ws (output, AW) and out_we (output, 1): downstream payload.
REQ-011 SHALL have ports fwd_ws (input, AW), fwd_hit (output, 1) and fwd_data (output, DW): forwarding query.
REQ-012 SHALL have port occupancy, output, 2: number of held entries (0..2).

Function
REQ-013 SHALL hold up to two entries: a main register driving out_* and a skid register.
REQ-014 SHALL drive in_ready as a registered value equal to NOT skid_valid, with no combinational path from out_ready.
REQ-015 SHALL accept an input beat when in_valid=1 and in_ready=1, and deliver an output beat when out_valid=1 and out_ready=1.
REQ-016 SHALL load an accepted beat into main when main is empty or is being delivered in the same cycle; otherwise it SHALL load the beat into skid.
REQ-017 SHALL move skid into main when main is delivered and skid is valid, with skid taking priority over a same-cycle input beat, so entries leave in acceptance order.
REQ-018 SHALL give latency of exactly 1 cycle from acceptance to out_valid when the stage is empty.
REQ-019 SHALL sustain 1 beat per cycle when out_ready is held at 1.
REQ-020 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, when ZERO_REG_WE_KILL=1, store we=0 for any accepted beat with in_ws=0.
REQ-022 SHALL drive out_we as main_we AND main_valid, so a bubble never asserts a write.
REQ-023 SHALL, on flush=1, clear main_valid, skid_valid and both stored we bits at the next edge, discard any same-cycle input beat, and set in_ready=1; payload data and ws registers SHALL hold their values.
REQ-024 SHALL give rst priority over flush, and flush priority over all handshakes.
REQ-025 SHALL compute fwd_hit combinationally as main_valid AND main_we AND (main_ws == fwd_ws) AND (fwd_ws != 0), and drive fwd_data = main_data.
REQ-026 SHALL drive occupancy as main_valid + skid_valid, registered.
REQ-027 SHALL never drop or duplicate a beat: every accepted beat is delivered exactly once unless flushed.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, set out_data=0, out_ws=0, out_we=0, out_valid=0, skid contents to 0, occupancy=0 and in_ready=1.
REQ-029 SHALL discard any in-flight beat on reset mid-stream, with no output beat on the cycle after reset is released.

Structure
REQ-030 SHALL take default DW and AW values and the occupancy width constant from the shared pipeline package, which also holds the common stage payload typedef {data, ws, we}.
REQ-031 SHALL instantiate sub-module pipe_entry_reg (one payload-plus-valid register with load and clear) twice, once for main and once for skid.

Verification
REQ-032 SHALL cover reset: hold rst=1 for 2 cycles -> out_valid=0, out_we=0, out_data=0, occupancy=0, in_ready=1.
REQ-033 SHALL cover streaming: out_ready=1, send data 0xA5A5A5A5 ws=3 we=1, then 0x1 ws=4 -> each beat appears 1 cycle after acceptance, back-to-back, in order.
REQ-034 SHALL cover backpressure: set out_ready=0 and send beats 0x10, 0x20 -> occupancy=2 and in_ready=0; a third beat is held upstream; then set out_ready=1 -> 0x10, 0x20 and the third beat are delivered in order, with no loss.
REQ-035 SHALL cover flush: with occupancy=2, assert flush together with in_valid and beat 0x30 -> next cycle out_valid=0, occupancy=0, in_ready=1, and 0x30 is never delivered.
REQ-036 SHALL cover the zero register and forwarding: accept ws=0 we=1 -> out_we=0; accept ws=7 we=1 data 0x55 and query fwd_ws=7 -> fwd_hit=1 and fwd_data=0x55; query fwd_ws=0 -> fwd_hit=0.
